// File: rtl/stage3_types_pkg.sv
// Shared types and constants for the stage-3 fetch unit.
// Holds the fetch FSM encoding, the NOP word and the default boot address.
package stage3_types_pkg;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/stage3_npc_select.sv
// Next-PC priority selector: trap/return, then fence re-fetch, then
// branch/jump, then sequential pc+4.
module stage3_npc_select (
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        npc_sel,
    input  logic [31:0] br_jmp_target,
    input  logic [31:0] pc_f,
    output logic [31:0] npc,
    output logic        redirect
);

    always_comb begin
        npc      = pc_f + 32'd4;
        redirect = insert_priv_pc | rollback | npc_sel;
        if (insert_priv_pc) begin
            npc = priv_pc;
        end else if (rollback) begin
            npc = rollback_pc;
        end else if (npc_sel) begin
            npc = br_jmp_target;
        end
    end

endmodule

// File: rtl/stage3_fetch_unit.sv
// Instruction fetch: PC register, memory request FSM and the
// fetch/execute latch. Orphaned responses are drained in DISCARD.
module stage3_fetch_unit
    import stage3_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic [31:0] br_jmp_target,
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        suppress_iren,
    input  logic        if_ex_stall,
    input  logic        if_ex_flush,
    output logic        iren,
    output logic [31:0] iaddr,
    input  logic        i_busy,
    input  logic [31:0] irdata,
    output logic        i_mem_busy,
    output logic [31:0] pc_f,
    output logic        fe_valid,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_instr,
    output logic        fe_mal_insn
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    logic         valid_q, valid_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  instr_q, instr_d;
    logic         mal_q, mal_d;

    logic [31:0]  npc;
    logic         redirect;
    logic         aligned;
    logic         complete;

    stage3_npc_select u_npc (
        .insert_priv_pc (insert_priv_pc),
        .priv_pc        (priv_pc),
        .rollback       (rollback),
        .rollback_pc    (rollback_pc),
        .npc_sel        (npc_sel),
        .br_jmp_target  (br_jmp_target),
        .pc_f           (pc_q),
        .npc            (npc),
        .redirect       (redirect)
    );

    assign aligned = (pc_q[1:0] == 2'b00);
    assign pc_d    = pc_en ? npc : pc_q;

    always_comb begin
        state_d    = state_q;
        stale_d    = stale_q;
        iren       = 1'b0;
        iaddr      = pc_q;
        i_mem_busy = 1'b0;
        unique case (state_q)
            FETCH: begin
                iren       = !suppress_iren && aligned;
                iaddr      = pc_q;
                i_mem_busy = iren && i_busy;
                // A redirect leaves the in-flight request orphaned
                if (redirect && pc_en && iren && i_busy) begin
                    stale_d = pc_q;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                iren       = 1'b1;
                iaddr      = stale_q;
                i_mem_busy = 1'b1;
                if (!i_busy) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign complete = (state_q == FETCH) && iren && !i_busy;

    always_comb begin
        valid_d = valid_q;
        fpc_d   = fpc_q;
        instr_d = instr_q;
        mal_d   = mal_q;
        if (if_ex_flush) begin
            valid_d = 1'b0;
        end else if (if_ex_stall) begin
            valid_d = valid_q;
        end else if (complete && !redirect) begin
            valid_d = 1'b1;
            fpc_d   = pc_q;
            instr_d = irdata;
            mal_d   = 1'b0;
        end else if ((state_q == FETCH) && !aligned) begin
            valid_d = 1'b1;
            fpc_d   = pc_q;
            instr_d = NOP_INSN;
            mal_d   = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            stale_q <= 32'h0;
            valid_q <= 1'b0;
            fpc_q   <= 32'h0;
            instr_q <= NOP_INSN;
            mal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            valid_q <= valid_d;
            fpc_q   <= fpc_d;
            instr_q <= instr_d;
            mal_q   <= mal_d;
        end
    end

    assign pc_f        = pc_q;
    assign fe_valid    = valid_q;
    assign fe_pc       = fpc_q;
    assign fe_instr    = instr_q;
    assign fe_mal_insn = mal_q;

endmodule

// File: tb/tb_stage3_fetch_unit.sv
// Directed bench for stage3_fetch_unit: sequential fetch, stalls,
// redirect discard, priority, misalignment and latch control.
module tb_stage3_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pc_en;
    logic        npc_sel;
    logic [31:0] br_jmp_target;
    logic        insert_priv_pc;
    logic [31:0] priv_pc;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        suppress_iren;
    logic        if_ex_stall;
    logic        if_ex_flush;
    logic        iren;
    logic [31:0] iaddr;
    logic        i_busy;
    logic [31:0] irdata;
    logic        i_mem_busy;
    logic [31:0] pc_f;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_instr;
    logic        fe_mal_insn;

    int n_assert = 0;
    int n_fail   = 0;

    stage3_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .pc_en          (pc_en),
        .npc_sel        (npc_sel),
        .br_jmp_target  (br_jmp_target),
        .insert_priv_pc (insert_priv_pc),
        .priv_pc        (priv_pc),
        .rollback       (rollback),
        .rollback_pc    (rollback_pc),
        .suppress_iren  (suppress_iren),
        .if_ex_stall    (if_ex_stall),
        .if_ex_flush    (if_ex_flush),
        .iren           (iren),
        .iaddr          (iaddr),
        .i_busy         (i_busy),
        .irdata         (irdata),
        .i_mem_busy     (i_mem_busy),
        .pc_f           (pc_f),
        .fe_valid       (fe_valid),
        .fe_pc          (fe_pc),
        .fe_instr       (fe_instr),
        .fe_mal_insn    (fe_mal_insn)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        RST = 1'b1; pc_en = 1'b0; npc_sel = 1'b0;
        br_jmp_target = '0; insert_priv_pc = 1'b0; priv_pc = '0;
        rollback = 1'b0; rollback_pc = '0; suppress_iren = 1'b0;
        if_ex_stall = 1'b0; if_ex_flush = 1'b0;
        i_busy = 1'b0; irdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_pc_f", pc_f, 32'h8000_0000);
        chk("rst_fe_valid", {31'b0, fe_valid}, 32'd0);
        chk("rst_fe_pc", fe_pc, 32'h0);
        chk("rst_fe_instr", fe_instr, 32'h0000_0013);
        chk("rst_fe_mal", {31'b0, fe_mal_insn}, 32'd0);
        RST = 1'b0;

        // Sequential fetch
        pc_en = 1'b1; irdata = 32'hA000_0000; settle();
        chk("seq0_iren", {31'b0, iren}, 32'd1);
        chk("seq0_iaddr", iaddr, 32'h8000_0000);
        tick();
        chk("seq0_valid", {31'b0, fe_valid}, 32'd1);
        chk("seq0_fe_pc", fe_pc, 32'h8000_0000);
        chk("seq0_instr", fe_instr, 32'hA000_0000);
        irdata = 32'hA000_0001; settle();
        chk("seq1_iaddr", iaddr, 32'h8000_0004);
        tick();
        chk("seq1_fe_pc", fe_pc, 32'h8000_0004);
        chk("seq1_instr", fe_instr, 32'hA000_0001);
        irdata = 32'hA000_0002; settle();
        chk("seq2_iaddr", iaddr, 32'h8000_0008);
        tick();
        chk("seq2_valid", {31'b0, fe_valid}, 32'd1);
        chk("seq2_fe_pc", fe_pc, 32'h8000_0008);
        chk("seq2_instr", fe_instr, 32'hA000_0002);
        chk("seq2_pc_f", pc_f, 32'h8000_000C);

        // Reset while a request is pending
        i_busy = 1'b1; RST = 1'b1; tick(); RST = 1'b0;
        chk("rst2_pc_f", pc_f, 32'h8000_0000);
        chk("rst2_iaddr", iaddr, 32'h8000_0000);

        // Busy memory: hold PC for three cycles
        pc_en = 1'b0; irdata = 32'hB000_0000;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("busy_imb", {31'b0, i_mem_busy}, 32'd1);
            chk("busy_iaddr", iaddr, 32'h8000_0000);
            tick();
            chk("busy_pc_f", pc_f, 32'h8000_0000);
            chk("busy_valid", {31'b0, fe_valid}, 32'd0);
        end
        i_busy = 1'b0; pc_en = 1'b1; tick();
        chk("busy_ld_valid", {31'b0, fe_valid}, 32'd1);
        chk("busy_ld_pc", fe_pc, 32'h8000_0000);
        chk("busy_ld_instr", fe_instr, 32'hB000_0000);
        chk("busy_ld_pc_f", pc_f, 32'h8000_0004);

        // Redirect while 8000_0008 is in flight
        irdata = 32'hB000_0001; tick();
        chk("pre_red_pc_f", pc_f, 32'h8000_0008);
        i_busy = 1'b1; npc_sel = 1'b1; br_jmp_target = 32'h8000_0100;
        irdata = 32'hDEAD_BEEF; tick();
        npc_sel = 1'b0; pc_en = 1'b0;
        chk("disc_pc_f", pc_f, 32'h8000_0100);
        chk("disc_valid0", {31'b0, fe_valid}, 32'd0);
        settle();
        chk("disc_iaddr0", iaddr, 32'h8000_0008);
        chk("disc_iren0", {31'b0, iren}, 32'd1);
        chk("disc_imb0", {31'b0, i_mem_busy}, 32'd1);
        tick();
        chk("disc_valid1", {31'b0, fe_valid}, 32'd0);
        i_busy = 1'b0; settle();
        chk("disc_iaddr1", iaddr, 32'h8000_0008);
        chk("disc_imb1", {31'b0, i_mem_busy}, 32'd1);
        tick();
        chk("disc_drop", {31'b0, fe_valid}, 32'd0);
        irdata = 32'hC000_0000; pc_en = 1'b1; settle();
        chk("post_iaddr", iaddr, 32'h8000_0100);
        chk("post_imb", {31'b0, i_mem_busy}, 32'd0);
        tick();
        chk("post_valid", {31'b0, fe_valid}, 32'd1);
        chk("post_fe_pc", fe_pc, 32'h8000_0100);
        chk("post_instr", fe_instr, 32'hC000_0000);

        // All three redirect sources at once
        insert_priv_pc = 1'b1; priv_pc = 32'h8000_0200;
        rollback = 1'b1; rollback_pc = 32'h8000_0300;
        npc_sel = 1'b1; br_jmp_target = 32'h8000_0400;
        tick();
        chk("prio_pc_f", pc_f, 32'h8000_0200);
        chk("prio_bubble", {31'b0, fe_valid}, 32'd0);
        insert_priv_pc = 1'b0; rollback = 1'b0;

        // Rollback beats branch
        rollback = 1'b1; rollback_pc = 32'h8000_0300; tick();
        chk("rb_pc_f", pc_f, 32'h8000_0300);
        rollback = 1'b0;

        // Misaligned target
        br_jmp_target = 32'h8000_0102; tick();
        chk("mal_pc_f", pc_f, 32'h8000_0102);
        npc_sel = 1'b0; pc_en = 1'b0; i_busy = 1'b1; settle();
        chk("mal_iren", {31'b0, iren}, 32'd0);
        chk("mal_imb", {31'b0, i_mem_busy}, 32'd0);
        tick();
        chk("mal_valid", {31'b0, fe_valid}, 32'd1);
        chk("mal_flag", {31'b0, fe_mal_insn}, 32'd1);
        chk("mal_instr", fe_instr, 32'h0000_0013);
        chk("mal_fe_pc", fe_pc, 32'h8000_0102);
        i_busy = 1'b0; npc_sel = 1'b1; br_jmp_target = 32'h8000_0200;
        pc_en = 1'b1; tick();
        npc_sel = 1'b0;
        chk("ret_pc_f", pc_f, 32'h8000_0200);

        // Stall and flush together drop the completion
        irdata = 32'hE000_0000; if_ex_stall = 1'b1; if_ex_flush = 1'b1;
        tick();
        chk("sf_valid", {31'b0, fe_valid}, 32'd0);
        if_ex_stall = 1'b0; if_ex_flush = 1'b0; irdata = 32'hE000_0001;
        tick();
        chk("norm_valid", {31'b0, fe_valid}, 32'd1);
        chk("norm_fe_pc", fe_pc, 32'h8000_0204);
        chk("norm_instr", fe_instr, 32'hE000_0001);
        chk("norm_mal", {31'b0, fe_mal_insn}, 32'd0);

        // Stall alone holds the latch
        if_ex_stall = 1'b1; irdata = 32'hE000_0002; tick();
        chk("st_valid", {31'b0, fe_valid}, 32'd1);
        chk("st_fe_pc", fe_pc, 32'h8000_0204);
        chk("st_instr", fe_instr, 32'hE000_0001);
        chk("st_mal", {31'b0, fe_mal_insn}, 32'd0);
        if_ex_stall = 1'b0;

        // Suppressed request gives a bubble
        suppress_iren = 1'b1; pc_en = 1'b0; settle();
        chk("sup_iren", {31'b0, iren}, 32'd0);
        tick();
        chk("sup_valid", {31'b0, fe_valid}, 32'd0);
        chk("sup_pc_f", pc_f, 32'h8000_020C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stage3_fetch_unit.md
STAGE3_FETCH_UNIT -- requirements
Module: stage3_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, meaning reset; synchronous and active-high.
REQ-004 SHALL have port pc_en, input, 1, meaning PC may advance or redirect this cycle.
REQ-005 SHALL have ports npc_sel (input, 1) and br_jmp_target (input, 32), meaning branch/jump redirect request and its target.
REQ-006 SHALL have ports insert_priv_pc (input, 1) and priv_pc (input, 32), meaning trap/return redirect request and its target.
REQ-007 SHALL have ports rollback (input, 1) and rollback_pc (input, 32), meaning fence re-fetch request and its target.
REQ-008 SHALL have ports suppress_iren, if_ex_stall and if_ex_flush, each input, 1, meaning hazard-unit controls.
REQ-009 SHALL have ports iren (output, 1), iaddr (output, 32), i_busy (input, 1) and irdata (input, 32), meaning the instruction-memory request bus.
REQ-010 SHALL have port i_mem_busy, output, 1, meaning fetch is waiting on memory; it feeds the hazard unit.
REQ-011 SHALL have port pc_f, output, 32, meaning the current fetch PC.
REQ-012 SHALL have ports fe_valid (output, 1), fe_pc (output, 32), fe_instr (output, 32) and fe_mal_insn (output, 1), meaning the fetch/execute latch.

Function
REQ-013 SHALL select the next PC by fixed priority: insert_priv_pc, then rollback, then npc_sel, then pc_f+4 (modulo 2^32).
REQ-014 SHALL load the selected next PC into pc_f only in cycles where pc_en=1; otherwise pc_f SHALL hold.
REQ-015 SHALL implement FSM states FETCH and DISCARD.
REQ-016 SHALL, in FETCH, drive iren = !suppress_iren && (pc_f[1:0]==0) and iaddr = pc_f.
REQ-017 SHALL treat a request as complete in the cycle where iren=1 and i_busy=0; irdata is sampled in that cycle.
REQ-018 SHALL drive i_mem_busy = iren && i_busy in FETCH, and i_mem_busy = 1 in DISCARD.
REQ-019 SHALL, when a redirect (REQ-013 first three sources) and pc_en occur with iren=1 and i_busy=1, capture the old iaddr into stale_addr and enter DISCARD next cycle.
REQ-020 SHALL, in DISCARD, hold iren=1 and iaddr=stale_addr until i_busy=0, drop that response, then return to FETCH next cycle.
REQ-021 SHALL ignore further redirects in DISCARD except updating pc_f per REQ-014.
REQ-022 SHALL update the latch each cycle by priority as follows:
 - if_ex_flush: fe_valid<=0.
 - else if_ex_stall: hold all fe_* outputs.
 - else completion in FETCH with no redirect this cycle: fe_valid<=1, fe_pc<=pc_f, fe_instr<=irdata, fe_mal_insn<=0.
 - else pc_f[1:0]!=0 in FETCH: fe_valid<=1, fe_pc<=pc_f, fe_instr<=32'h0000_0013, fe_mal_insn<=1, and no request issued.
 - else fe_valid<=0 (bubble).
REQ-023 SHALL ensure irdata is never latched while in DISCARD.

Reset
REQ-024 SHALL, while RST=1 at a clock edge, set pc_f=RESET_PC, state=FETCH, stale_addr=0, fe_valid=0, fe_pc=0, fe_instr=32'h0000_0013 and fe_mal_insn=0.
REQ-025 SHALL, if reset occurs mid-request or in DISCARD, abandon the request; the first post-reset request is to RESET_PC.

Structure
REQ-026 SHALL place fetch_state_t (FETCH, DISCARD), the NOP constant 32'h0000_0013 and the default RESET_PC in shared package stage3_types_pkg.
REQ-027 SHALL implement next-PC priority selection as combinational sub-module stage3_npc_select; the FSM and latch reside in stage3_fetch_unit.

Verification
REQ-028 SHALL verify: reset released, i_busy=0, pc_en=1 -> iaddr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, with fe_valid=1 carrying matching irdata.
REQ-029 SHALL verify: i_busy=1 for 3 cycles at 8000_0000 -> i_mem_busy=1, iaddr stable, pc_f held, fe_valid=0 for those cycles, then latch loads.
REQ-030 SHALL verify: npc_sel=1 with target 8000_0100 while 8000_0008 is busy -> DISCARD, iaddr stays 8000_0008 until i_busy=0, its data is never latched, next request is 8000_0100.
REQ-031 SHALL verify: insert_priv_pc=1 (priv_pc 8000_0200), rollback=1 and npc_sel=1 in the same cycle -> pc_f=8000_0200.
REQ-032 SHALL verify: br_jmp_target=8000_0102 -> iren=0, fe_mal_insn=1, fe_instr=0000_0013, fe_pc=8000_0102.
REQ-033 SHALL verify: if_ex_stall and if_ex_flush both asserted during a completion -> fe_valid=0; if_ex_stall alone -> fe_* unchanged.
